// File: rtl/latency_credit_buffer_pkg.sv
// latency_credit_buffer_pkg
//   Shared sizing helpers for the latency credit buffer.
//   cnt_w   : width of a counter that must hold 0..depth
//   ptr_w   : width of a ring pointer (at least 1 bit)
//   ptr_inc : ring pointer increment with wrap at depth-1 (any depth)
package latency_credit_buffer_pkg;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/latency_credit_buffer_if.sv
// latency_credit_buffer_if
//   Handshake bundle around the credit buffer.
//   issue_ok/issue         : credit grant to, and launch from, the upstream launcher
//   pipe_valid/pipe_data   : items emerging from the fixed-latency pipeline
//   m_valid/m_ready/m_data : downstream valid/ready output
//   slave  : the buffer side
//   master : the launcher / pipeline / consumer side
interface latency_credit_buffer_if #(
   parameter int WIDTH = 16
);
   logic             issue_ok;
   logic             issue;
   logic             pipe_valid;
   logic [WIDTH-1:0] pipe_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport slave (
      output issue_ok, m_valid, m_data,
      input  issue, pipe_valid, pipe_data, m_ready
   );

   modport master (
      input  issue_ok, m_valid, m_data,
      output issue, pipe_valid, pipe_data, m_ready
   );
endinterface

// File: rtl/lcb_ring_mem.sv
// lcb_ring_mem
//   DEPTH x WIDTH storage for the credit buffer. Synchronous write,
//   asynchronous read, data is never reset.
//   clk          : clock
//   we/waddr     : write strobe and slot
//   wdata        : write data
//   raddr/rdata  : combinational read port
module lcb_ring_mem
   import latency_credit_buffer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/latency_credit_buffer.sv
// latency_credit_buffer
//   Receive-side buffer for a fixed-latency, non-stallable pipeline. Hands
//   out DEPTH credits to the launcher, catches every item LATENCY cycles
//   later and presents it on a valid/ready output. Since in-flight plus
//   stored items never exceed DEPTH, downstream backpressure never needs
//   to stall the pipeline.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : latency_credit_buffer_if.slave (issue/pipe/output handshakes)
//   credits    : free credits
//   count      : stored entries
//   overflow   : sticky, pipe item arrived while storage was full
//   proto_err  : sticky, issue seen while issue_ok was low
//   hwm        : high-water mark of count
//   Optional: define LATENCY_CREDIT_BUFFER_HWM_EN to build the hwm register;
//   otherwise hwm reads 0.
module latency_credit_buffer
   import latency_credit_buffer_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 3,
   parameter int DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   latency_credit_buffer_if.slave      bus,
   output logic [cnt_w(DEPTH)-1:0]     credits,
   output logic [cnt_w(DEPTH)-1:0]     count,
   output logic                        overflow,
   output logic                        proto_err,
   output logic [cnt_w(DEPTH)-1:0]     hwm
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   if (DEPTH < 1 || LATENCY < 0) begin : g_param_check
      $error("latency_credit_buffer: DEPTH must be >= 1 and LATENCY >= 0");
   end

   logic [CW-1:0] credits_q, credits_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          overflow_q, overflow_d;
   logic          proto_err_q, proto_err_d;
   logic          issue_ok;
   logic          take;
   logic          pop;
   logic          push;

   assign issue_ok = (credits_q != '0) && !rst;
   assign take     = bus.issue && issue_ok;
   assign pop      = (count_q != '0) && bus.m_ready;
   // When full, a pop frees the slot the incoming item is written into.
   assign push     = bus.pipe_valid && ((count_q < CW'(DEPTH)) || pop);

   always_comb begin
      credits_d   = credits_q;
      count_d     = count_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      overflow_d  = overflow_q | (bus.pipe_valid && !push);
      proto_err_d = proto_err_q | (bus.issue && !issue_ok);

      if (take && !pop) begin
         credits_d = credits_q - CW'(1);
      end else if (pop && !take) begin
         credits_d = credits_q + CW'(1);
      end

      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      if (push) begin
         wptr_d = PW'(ptr_inc(int'(wptr_q), DEPTH));
      end
      if (pop) begin
         rptr_d = PW'(ptr_inc(int'(rptr_q), DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q   <= CW'(DEPTH);
         count_q     <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         credits_q   <= credits_d;
         count_q     <= count_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         overflow_q  <= overflow_d;
         proto_err_q <= proto_err_d;
      end
   end

   lcb_ring_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && !rst),
      .waddr (wptr_q),
      .wdata (bus.pipe_data),
      .raddr (rptr_q),
      .rdata (bus.m_data)
   );

`ifdef LATENCY_CREDIT_BUFFER_HWM_EN
   logic [CW-1:0] hwm_q, hwm_d;

   assign hwm_d = (count_d > hwm_q) ? count_d : hwm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign hwm = hwm_q;
`else
   assign hwm = '0;
`endif

   assign bus.issue_ok = issue_ok;
   assign bus.m_valid  = (count_q != '0);
   assign credits      = credits_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_latency_credit_buffer.sv
// tb_latency_credit_buffer
//   Two instances (DEPTH=4 and DEPTH=5, WIDTH=8) driven one at a time; the
//   idle one is held in reset. A queue-based reference model tracks the
//   expected buffer contents, credits and sticky flags; a 3-stage delay line
//   stands in for the pipeline.
module tb_latency_credit_buffer;

   localparam int W   = 8;
   localparam int LAT = 3;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           sel;
   logic         rst_r, issue_r, pipe_v, m_ready_r;
   logic [W-1:0] pipe_d;

   latency_credit_buffer_if #(.WIDTH(W)) bus4 ();
   latency_credit_buffer_if #(.WIDTH(W)) bus5 ();

   logic       rst4, rst5;
   logic [2:0] cred4, cnt4, hwm4, cred5, cnt5, hwm5;
   logic       ovf4, perr4, ovf5, perr5;

   assign rst4            = (sel == 0) ? rst_r : 1'b1;
   assign rst5            = (sel == 1) ? rst_r : 1'b1;
   assign bus4.issue      = (sel == 0) && issue_r;
   assign bus4.pipe_valid = (sel == 0) && pipe_v;
   assign bus4.pipe_data  = pipe_d;
   assign bus4.m_ready    = (sel == 0) && m_ready_r;
   assign bus5.issue      = (sel == 1) && issue_r;
   assign bus5.pipe_valid = (sel == 1) && pipe_v;
   assign bus5.pipe_data  = pipe_d;
   assign bus5.m_ready    = (sel == 1) && m_ready_r;

   latency_credit_buffer #(.WIDTH(W), .LATENCY(LAT), .DEPTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst4),
      .bus       (bus4),
      .credits   (cred4),
      .count     (cnt4),
      .overflow  (ovf4),
      .proto_err (perr4),
      .hwm       (hwm4)
   );

   latency_credit_buffer #(.WIDTH(W), .LATENCY(LAT), .DEPTH(5)) u_dut5 (
      .clk       (clk),
      .rst       (rst5),
      .bus       (bus5),
      .credits   (cred5),
      .count     (cnt5),
      .overflow  (ovf5),
      .proto_err (perr5),
      .hwm       (hwm5)
   );

   logic         a_ok, a_mv, a_ovf, a_perr;
   logic [W-1:0] a_md;
   logic [2:0]   a_cred, a_cnt, a_hwm;

   always_comb begin
      if (sel == 0) begin
         a_ok = bus4.issue_ok; a_mv = bus4.m_valid; a_md = bus4.m_data;
         a_cred = cred4; a_cnt = cnt4; a_hwm = hwm4; a_ovf = ovf4; a_perr = perr4;
      end else begin
         a_ok = bus5.issue_ok; a_mv = bus5.m_valid; a_md = bus5.m_data;
         a_cred = cred5; a_cnt = cnt5; a_hwm = hwm5; a_ovf = ovf5; a_perr = perr5;
      end
   end

   // reference model state
   int           d_m;
   logic [W-1:0] q_m [$];
   int           cred_m;
   int           hwm_m;
   bit           ovf_m, perr_m;
   bit           dl_v [LAT];
   logic [W-1:0] dl_d [LAT];

   int checks;
   int failures;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", tag, sel + 4, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_m.delete();
      cred_m = d_m;
      hwm_m  = 0;
      ovf_m  = 1'b0;
      perr_m = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         dl_v[i] = 1'b0;
         dl_d[i] = '0;
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs
   // against the model, then advance the model to match the rising edge.
   // obey=1 makes the launcher respect issue_ok.
   task automatic cycle(input bit r, input bit iss, input bit obey, input logic [W-1:0] idata,
                        input bit rdy, input bit fv, input logic [W-1:0] fd);
      bit           ok, launch, take, pop, push, pv;
      logic [W-1:0] pd;
      int           exp_hwm;
      @(negedge clk);
      ok     = (cred_m != 0) && !r;
      launch = obey ? (iss && ok) : iss;
      pv     = fv || dl_v[LAT-1];
      pd     = fv ? fd : dl_d[LAT-1];
      rst_r     = r;
      issue_r   = launch;
      m_ready_r = rdy;
      pipe_v    = pv;
      pipe_d    = pd;
      #1;
`ifdef LATENCY_CREDIT_BUFFER_HWM_EN
      exp_hwm = hwm_m;
`else
      exp_hwm = 0;
`endif
      chk_eq("issue_ok", a_ok, ok);
      chk_eq("m_valid", a_mv, q_m.size() != 0);
      if (q_m.size() != 0) chk_eq("m_data", a_md, q_m[0]);
      chk_eq("credits", a_cred, cred_m);
      chk_eq("count", a_cnt, q_m.size());
      chk_eq("overflow", a_ovf, ovf_m);
      chk_eq("proto_err", a_perr, perr_m);
      chk_eq("hwm", a_hwm, exp_hwm);
      if (r) begin
         model_reset();
      end else begin
         take = launch && ok;
         pop  = (q_m.size() != 0) && rdy;
         push = pv && ((q_m.size() < d_m) || pop);
         if (launch && !ok) perr_m = 1'b1;
         if (pv && !push) ovf_m = 1'b1;
         if (pop) void'(q_m.pop_front());
         if (push) q_m.push_back(pd);
         cred_m = cred_m - int'(take) + int'(pop);
         if (q_m.size() > hwm_m) hwm_m = q_m.size();
         for (int i = LAT - 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
         end
         dl_v[0] = take;
         dl_d[0] = idata;
      end
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 1'b0, 1'b1, '0, rdy, 1'b0, '0);
   endtask

   task automatic send(input logic [W-1:0] d, input bit rdy);
      cycle(1'b0, 1'b1, 1'b1, d, rdy, 1'b0, '0);
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 49) != 0, W'($urandom), $urandom_range(0, 1) == 1,
               1'b0, '0);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      sel = 0; d_m = 4;
      rst_r = 1'b1; issue_r = 1'b0; pipe_v = 1'b0; pipe_d = '0; m_ready_r = 1'b0;
      model_reset();

      // reset: first cycle unchecked (state still unknown), second checked
      @(negedge clk);
      cycle(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      idle(1'b0);
      chk_eq("rst_credits", a_cred, 4);

      // fill 0x11..0x14 with no downstream ready
      for (int i = 0; i < 4; i++) send(W'(8'h11 + i), 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      chk_eq("fill_count", a_cnt, 4);
      chk_eq("fill_credits", a_cred, 0);
      chk_eq("fill_head", a_md, 8'h11);

      // drain
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         chk_eq("drain_data", a_md, W'(8'h11 + i));
      end
      idle(1'b0);
      chk_eq("drain_count", a_cnt, 0);
      chk_eq("drain_valid", a_mv, 0);

      // refill, then overflow and protocol errors
      for (int i = 0; i < 4; i++) send(W'(8'h21 + i), 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      cycle(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, 8'h55);
      idle(1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, '0);
      idle(1'b0);
      idle(1'b0);
      chk_eq("err_overflow", a_ovf, 1);
      chk_eq("err_proto", a_perr, 1);
      chk_eq("err_credits", a_cred, 0);
      chk_eq("err_head", a_md, 8'h21);

      // reset with two stored and two in flight
      idle(1'b1);
      idle(1'b1);
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      chk_eq("mid_count", a_cnt, 2);
      cycle(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      idle(1'b0);
      chk_eq("mid_rst_count", a_cnt, 0);
      chk_eq("mid_rst_credits", a_cred, 4);
      chk_eq("mid_rst_ovf", a_ovf, 0);
      chk_eq("mid_rst_hwm", a_hwm, 0);
      for (int i = 0; i < 6; i++) idle(1'b0);

      random_run(400);

      // switch to the DEPTH=5 instance
      @(negedge clk);
      rst_r = 1'b1; issue_r = 1'b0; pipe_v = 1'b0; m_ready_r = 1'b0;
      sel = 1; d_m = 5;
      model_reset();
      cycle(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 30; i++) begin
         send(W'(i), 1'b1);
         if (i >= 5) begin
            chk_eq("stream_credits", a_cred, 1);
            chk_eq("stream_valid", a_mv, 1);
            chk_eq("stream_data", a_md, W'(i - 4));
         end
      end
      for (int i = 0; i < 6; i++) idle(1'b1);
      chk_eq("stream_perr", a_perr, 0);

      random_run(250);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/latency_credit_buffer.md
Name: latency_credit_buffer

Overview:
- Receive-side companion to a fixed-latency, non-stallable pipeline such as a z^-n delay chain.
- Issues credits to the upstream launcher, catches every item that emerges LATENCY cycles later, and presents the items downstream on a valid/ready interface.
- Backpressure from downstream never requires stalling the pipeline, because in-flight plus stored items never exceed DEPTH.

Parameters:
- WIDTH, 16: data bit width.
- LATENCY, 3: pipeline latency from issue to pipe_valid, in cycles; informational only, must be >= 0.
- DEPTH, 8: storage entries and total credits; must be >= 1. Full-throughput operation needs DEPTH >= LATENCY+2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- issue_ok  out  1  credit available; upstream may launch this cycle
- issue  in  1  upstream launched one item into the pipeline this cycle
- pipe_valid  in  1  pipeline output strobe
- pipe_data  in  WIDTH  pipeline output data
- m_valid  out  1  head entry available
- m_ready  in  1  downstream accepts head
- m_data  out  WIDTH  head entry data
- credits  out  $clog2(DEPTH+1)  free credits
- count  out  $clog2(DEPTH+1)  stored entries
- overflow  out  1  sticky: pipe_valid arrived while storage was full
- proto_err  out  1  sticky: issue asserted while issue_ok=0
- hwm  out  $clog2(DEPTH+1)  high-water mark of count (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - Next cycle: credits=DEPTH, count=0, m_valid=0, overflow=0, proto_err=0, hwm=0, read/write pointers=0.
  - rst dominates every other input. In-flight pipeline items arriving after reset are stored normally, with no credit check; the system owner resets pipeline and buffer together.
- issue_ok is combinational: (credits != 0) && !rst.
- Events:
  - take = issue && issue_ok
  - pop = m_valid && m_ready
  - push = pipe_valid && (count < DEPTH || pop)
- Credit counter: credits_next = credits - take + pop. Simultaneous take and pop leave credits unchanged. The counter never wraps; saturation is impossible by construction.
- issue while issue_ok=0: ignored for accounting; set proto_err.
- Storage: circular buffer of DEPTH entries.
  - Write pointer advances on push, read pointer on pop; both wrap from DEPTH-1 to 0 (DEPTH need not be a power of 2).
  - count_next = count + push - pop.
- Full with simultaneous pipe_valid and pop: both occur; count stays DEPTH, and the entry is written into the slot freed this cycle.
- pipe_valid while full and no pop: data dropped; set overflow; count unchanged.
- Output:
  - m_valid = (count != 0), registered state.
  - m_data = entry at the read pointer.
  - No bypass: an item arriving on pipe_valid in cycle t is visible at m_data no earlier than cycle t+1.
  - m_data holds stable while m_valid && !m_ready.
- Throughput: one item per cycle sustained when m_ready=1 and DEPTH >= LATENCY+2.
- Empty with pop impossible, since m_valid=0.

Optional Feature:
- Macro: LATENCY_CREDIT_BUFFER_HWM_EN.
- Defined: hwm register tracks max(count_next) since reset; cleared by rst; useful for sizing DEPTH.
- Undefined: hwm tied to 0; no register is generated.

Decomposition:
- Package latency_credit_buffer_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1)
  - function ptr_w(depth) returning max(1, $clog2(depth))
  - function ptr_inc(ptr, depth) implementing non-power-of-2 wrap
- One sub-module, lcb_ring_mem: DEPTH x WIDTH storage.
  - Synchronous write on we/waddr.
  - Asynchronous read on raddr.
  - No reset on data.
- All counters and pointer logic live in the top level.

Test Plan:
(WIDTH=8, LATENCY=3, DEPTH=4; pipeline modelled by a 3-cycle delay of issue and data.)
1. Reset: rst=1 for 2 cycles, then 0 -> credits=4, count=0, m_valid=0, issue_ok=1, overflow=0, proto_err=0.
2. Fill: issue data 0x11..0x14 back-to-back with m_ready=0 -> issue_ok=0 the cycle after the 4th issue; count reaches 4; m_data=0x11 stable; credits=0.
3. Drain: from test 2, m_ready=1 for 4 cycles -> m_data=0x11, 0x12, 0x13, 0x14 on consecutive cycles; count=0, credits=4, m_valid=0 afterwards.
4. Steady stream: DEPTH=5, issue every cycle, m_ready=1 -> 1 item/cycle after the 4-cycle fill; credits constant at 1 once steady; no proto_err.
5. Errors, both starting from count=4 and credits=0:
   - Force pipe_valid=1 with data 0x55 and m_ready=0 -> overflow=1 and stays 1; count=4; 0x55 never appears on m_data.
   - Drive issue=1 -> proto_err=1; credits stays 0.
6. Reset mid-stream: rst=1 while count=2 and 2 items are in flight -> next cycle count=0, credits=4, m_valid=0, sticky flags cleared; hwm=0 if HWM_EN is defined.
